mcdf_arbiter: RTL and testbench

//  Packet-level arbiter between the MCDF slave channels and the formatter.

---
 rtl/mcdf_arbiter_pkg.sv | 40 ++++
 rtl/mcdf_arbiter_arb_prio_rr_pick.sv | 63 ++++++
 rtl/mcdf_arbiter.sv | 142 ++++++++++++++
 tb/tb_mcdf_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mcdf_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mcdf_arbiter_pkg
// Shared definitions for the MCDF packet arbiter:
//   - default geometry (channel count, data width, field widths)
//   - packet-length code -> word-count constants and decode helper
//   - arbiter FSM state encoding
// -----------------------------------------------------------------------------
package mcdf_arbiter_pkg;

  localparam int NCH_DEF       = 3;
  localparam int DW_DEF        = 32;
  localparam int PRIO_WIDTH    = 2;
  localparam int PAC_LEN_WIDTH = 3;
  localparam int CH_ID_W       = 2;
  localparam int CNT_W         = 6;

  localparam logic [CNT_W-1:0] LEN_WORDS_0 = 6'd4;
  localparam logic [CNT_W-1:0] LEN_WORDS_1 = 6'd8;
  localparam logic [CNT_W-1:0] LEN_WORDS_2 = 6'd16;
  localparam logic [CNT_W-1:0] LEN_WORDS_3 = 6'd32;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_XFER = 1'b1
  } arb_state_e;

  // Codes above 3 are reserved and saturate to the longest packet.
  function automatic logic [CNT_W-1:0] decode_len(input logic [PAC_LEN_WIDTH-1:0] code);
    logic [CNT_W-1:0] words;
    case (code)
      3'd0:    words = LEN_WORDS_0;
      3'd1:    words = LEN_WORDS_1;
      3'd2:    words = LEN_WORDS_2;
      3'd3:    words = LEN_WORDS_3;
      default: words = LEN_WORDS_3;
    endcase
    return words;
  endfunction

endpackage

// File: rtl/mcdf_arbiter_arb_prio_rr_pick.sv
// -----------------------------------------------------------------------------
// arb_prio_rr_pick
// Combinational winner selection: lowest priority value wins, ties resolved
// by taking the first tied channel strictly after rr_ptr_i (modulo NCH).
// Ports:
//   elig_i     eligible channel mask
//   prio_i     per-channel priority, ch0 in LSBs (0 = highest)
//   rr_ptr_i   last granted channel
//   winner_o   selected channel id (valid when any_elig_o)
//   any_elig_o at least one channel eligible
// -----------------------------------------------------------------------------
module arb_prio_rr_pick
  import mcdf_arbiter_pkg::*;
#(
  parameter int NCH    = NCH_DEF,
  parameter int PRIO_W = PRIO_WIDTH
) (
  input  logic [NCH-1:0]        elig_i,
  input  logic [NCH*PRIO_W-1:0] prio_i,
  input  logic [CH_ID_W-1:0]    rr_ptr_i,
  output logic [CH_ID_W-1:0]    winner_o,
  output logic                  any_elig_o
);

  logic [PRIO_W-1:0] min_prio_s;
  logic [NCH-1:0]    cand_s;
  logic              found_s;
  logic              hit_s;

  // Lowest priority value among eligible channels.
  always_comb begin
    min_prio_s = '1;
    for (int i = 0; i < NCH; i++) begin
      min_prio_s = (elig_i[i] && (prio_i[i*PRIO_W +: PRIO_W] < min_prio_s)) ?
                   prio_i[i*PRIO_W +: PRIO_W] : min_prio_s;
    end
  end

  // Eligible channels tied at that lowest value.
  always_comb begin
    cand_s = '0;
    for (int i = 0; i < NCH; i++) begin
      cand_s[i] = elig_i[i] && (prio_i[i*PRIO_W +: PRIO_W] == min_prio_s);
    end
  end

  // Walk the channels in order rr_ptr+1, rr_ptr+2, ... and keep the first candidate.
  always_comb begin
    winner_o = '0;
    found_s  = 1'b0;
    hit_s    = 1'b0;
    for (int off = 1; off <= NCH; off++) begin
      for (int i = 0; i < NCH; i++) begin
        hit_s    = !found_s && cand_s[i] && (((int'(rr_ptr_i) + off) % NCH) == i);
        winner_o = hit_s ? CH_ID_W'(i) : winner_o;
        found_s  = found_s | hit_s;
      end
    end
  end

  assign any_elig_o = |elig_i;

endmodule

// File: rtl/mcdf_arbiter.sv
// -----------------------------------------------------------------------------
// mcdf_arbiter
// Packet-level arbiter between the MCDF slave channels and the formatter.
// Grants one channel at a time and streams exactly one packet from it.
// Ports:
//   clk_i, rstn_i          clock, async active-low reset
//   slv_en_i/prio_i/pkglen_i  per-channel config, sampled only at grant
//   slv_req_i              channel holds at least one full packet
//   slv_val_i, slv_data_i  channel head word and its valid
//   slv_ack_o              pop strobe to the granted channel FIFO
//   fmt_ready_i            formatter accepts a word this cycle
//   fmt_val_o/data_o       word to formatter
//   fmt_ch_id_o            granted channel id
//   fmt_sop_o/eop_o        first/last word of packet (qualified by fmt_val_o)
//   busy_o                 high while a packet is in progress
// -----------------------------------------------------------------------------
module mcdf_arbiter
  import mcdf_arbiter_pkg::*;
#(
  parameter int NCH    = NCH_DEF,
  parameter int DW     = DW_DEF,
  parameter int PRIO_W = PRIO_WIDTH,
  parameter int LEN_W  = PAC_LEN_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [NCH-1:0]        slv_en_i,
  input  logic [NCH*PRIO_W-1:0] slv_prio_i,
  input  logic [NCH*LEN_W-1:0]  slv_pkglen_i,
  input  logic [NCH-1:0]        slv_req_i,
  input  logic [NCH-1:0]        slv_val_i,
  input  logic [NCH*DW-1:0]     slv_data_i,
  output logic [NCH-1:0]        slv_ack_o,
  input  logic                  fmt_ready_i,
  output logic                  fmt_val_o,
  output logic [DW-1:0]         fmt_data_o,
  output logic [CH_ID_W-1:0]    fmt_ch_id_o,
  output logic                  fmt_sop_o,
  output logic                  fmt_eop_o,
  output logic                  busy_o
);

  arb_state_e         state_q;
  logic [CH_ID_W-1:0] gnt_q;
  logic [CH_ID_W-1:0] rr_ptr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               sop_q;

  logic [NCH-1:0]     elig_s;
  logic [CH_ID_W-1:0] winner_s;
  logic               any_elig_s;
  logic [LEN_W-1:0]   win_len_s;
  logic               gnt_val_s;
  logic [DW-1:0]      gnt_data_s;
  logic               in_xfer_s;
  logic               xfer_s;
  logic               last_word_s;

  assign elig_s = slv_en_i & slv_req_i;

  arb_prio_rr_pick #(
    .NCH    (NCH),
    .PRIO_W (PRIO_W)
  ) u_pick (
    .elig_i     (elig_s),
    .prio_i     (slv_prio_i),
    .rr_ptr_i   (rr_ptr_q),
    .winner_o   (winner_s),
    .any_elig_o (any_elig_s)
  );

  // Length code of the channel that would be granted this cycle.
  always_comb begin
    win_len_s = '0;
    for (int i = 0; i < NCH; i++) begin
      win_len_s = (winner_s == CH_ID_W'(i)) ? slv_pkglen_i[i*LEN_W +: LEN_W] : win_len_s;
    end
  end

  // Head word and valid of the granted channel.
  always_comb begin
    gnt_val_s  = 1'b0;
    gnt_data_s = '0;
    for (int i = 0; i < NCH; i++) begin
      gnt_val_s  = (gnt_q == CH_ID_W'(i)) ? slv_val_i[i] : gnt_val_s;
      gnt_data_s = (gnt_q == CH_ID_W'(i)) ? slv_data_i[i*DW +: DW] : gnt_data_s;
    end
  end

  assign in_xfer_s   = (state_q == ARB_XFER);
  assign xfer_s      = in_xfer_s & gnt_val_s & fmt_ready_i;
  assign last_word_s = (cnt_q == CNT_W'(1));

  // Output decode; everything is forced low outside a packet so reset leaves all outputs 0.
  always_comb begin
    fmt_val_o   = in_xfer_s & gnt_val_s;
    fmt_data_o  = in_xfer_s ? gnt_data_s : '0;
    fmt_ch_id_o = in_xfer_s ? gnt_q : '0;
    fmt_sop_o   = in_xfer_s & sop_q;
    fmt_eop_o   = in_xfer_s & last_word_s;
    busy_o      = in_xfer_s;
    slv_ack_o   = '0;
    for (int i = 0; i < NCH; i++) begin
      slv_ack_o[i] = xfer_s & (gnt_q == CH_ID_W'(i));
    end
  end

  // Arbiter FSM: grant, word counting, sop tracking and round-robin pointer.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= ARB_IDLE;
      gnt_q    <= '0;
      rr_ptr_q <= CH_ID_W'(NCH - 1);
      cnt_q    <= '0;
      sop_q    <= 1'b0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (any_elig_s) begin
            gnt_q    <= winner_s;
            rr_ptr_q <= winner_s;
            cnt_q    <= decode_len(win_len_s);
            sop_q    <= 1'b1;
            state_q  <= ARB_XFER;
          end
        end
        ARB_XFER: begin
          // Stalls (no valid or no ready) hold cnt, sop and gnt.
          if (xfer_s) begin
            cnt_q   <= cnt_q - CNT_W'(1);
            sop_q   <= 1'b0;
            state_q <= last_word_s ? ARB_IDLE : ARB_XFER;
          end
        end
        default: begin
          state_q <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mcdf_arbiter.sv
module tb_mcdf_arbiter;

  localparam int NCH = 3;
  localparam int DW  = 32;

  logic            clk = 1'b0;
  logic            rstn;
  logic [NCH-1:0]  en_v, req_v, val_v;
  logic [1:0]      prio_a [NCH];
  logic [2:0]      len_a  [NCH];
  logic [DW-1:0]   data_a [NCH];
  logic            ready;

  logic [NCH*2-1:0]  prio_v;
  logic [NCH*3-1:0]  len_v;
  logic [NCH*DW-1:0] data_v;

  logic [NCH-1:0] slv_ack_s;
  logic           fmt_val_s, sop_s, eop_s, busy_s;
  logic [DW-1:0]  fmt_data_s;
  logic [1:0]     ch_id_s;

  assign prio_v = {prio_a[2], prio_a[1], prio_a[0]};
  assign len_v  = {len_a[2], len_a[1], len_a[0]};
  assign data_v = {data_a[2], data_a[1], data_a[0]};

  always #5 clk = ~clk;

  mcdf_arbiter dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .slv_en_i     (en_v),
    .slv_prio_i   (prio_v),
    .slv_pkglen_i (len_v),
    .slv_req_i    (req_v),
    .slv_val_i    (val_v),
    .slv_data_i   (data_v),
    .slv_ack_o    (slv_ack_s),
    .fmt_ready_i  (ready),
    .fmt_val_o    (fmt_val_s),
    .fmt_data_o   (fmt_data_s),
    .fmt_ch_id_o  (ch_id_s),
    .fmt_sop_o    (sop_s),
    .fmt_eop_o    (eop_s),
    .busy_o       (busy_s)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int ack_cnt [NCH];

  // Reference model: packet in progress, channel, words left, first-word flag, last grant.
  bit m_busy;
  int m_ch, m_left, m_last;
  bit m_first;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
  endtask

  function automatic int words_of(input logic [2:0] code);
    return (code >= 3'd3) ? 32 : (4 << code);
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_ch = 0; m_left = 0; m_first = 1'b0; m_last = NCH - 1;
  endtask

  // Scan channels in round-robin order after the last grant; a strictly
  // lower priority value replaces the current pick, so ties keep the earliest.
  task automatic model_arbitrate();
    int best = -1;
    for (int k = 1; k <= NCH; k++) begin
      int c = (m_last + k) % NCH;
      if (en_v[c] && req_v[c] && (best < 0 || prio_a[c] < prio_a[best])) best = c;
    end
    if (best >= 0) begin
      m_busy = 1'b1; m_ch = best; m_left = words_of(len_a[best]);
      m_first = 1'b1; m_last = best;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy_s), 32'(0));
    chk({tag, "_val"},  32'(fmt_val_s), 32'(0));
    chk({tag, "_ack"},  32'(slv_ack_s), 32'(0));
    chk({tag, "_sop"},  32'(sop_s), 32'(0));
    chk({tag, "_eop"},  32'(eop_s), 32'(0));
    chk({tag, "_chid"}, 32'(ch_id_s), 32'(0));
    chk({tag, "_data"}, fmt_data_s, 32'(0));
  endtask

  // One clock: called just after a falling edge with inputs already driven.
  task automatic step();
    logic [NCH-1:0] exp_ack;
    logic           ev;
    #1;
    for (int i = 0; i < NCH; i++) ack_cnt[i] += int'(slv_ack_s[i]);
    if (m_busy) begin
      ev      = val_v[m_ch];
      exp_ack = '0;
      if (ev && ready) exp_ack[m_ch] = 1'b1;
      chk("busy", 32'(busy_s), 32'(1));
      chk("ch_id", 32'(ch_id_s), 32'(m_ch));
      chk("val", 32'(fmt_val_s), 32'(ev));
      chk("ack", 32'(slv_ack_s), 32'(exp_ack));
      if (ev) begin
        chk("data", fmt_data_s, data_a[m_ch]);
        chk("sop", 32'(sop_s), 32'(m_first));
        chk("eop", 32'(eop_s), 32'(m_left == 1));
      end
    end else begin
      chk("idle_busy", 32'(busy_s), 32'(0));
      chk("idle_val", 32'(fmt_val_s), 32'(0));
      chk("idle_ack", 32'(slv_ack_s), 32'(0));
    end
    @(posedge clk);
    if (m_busy) begin
      if (val_v[m_ch] && ready) begin
        m_left--; m_first = 1'b0;
        if (m_left == 0) m_busy = 1'b0;
      end
    end else begin
      model_arbitrate();
    end
    @(negedge clk);
  endtask

  task automatic quiet_inputs();
    en_v = '0; req_v = '0; val_v = '0; ready = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      prio_a[i] = 2'd0; len_a[i] = 3'd0; data_a[i] = $urandom;
    end
  endtask

  task automatic clear_acks();
    for (int i = 0; i < NCH; i++) ack_cnt[i] = 0;
  endtask

  // Finish any packet in flight with no new requests, bounded.
  task automatic drain();
    req_v = '0; val_v = '1; ready = 1'b1;
    for (int c = 0; c < 80 && m_busy; c++) step();
    if (m_busy) chk("drain_timeout", 32'(0), 32'(1));
    step();
    clear_acks();
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("rst");
    rstn = 1'b1;
    model_reset();
  endtask

  initial begin
    quiet_inputs();
    model_reset();
    clear_acks();
    apply_reset();

    // 1: single channel, 4-word packet
    en_v = 3'b010; req_v = 3'b010; val_v = 3'b111; ready = 1'b1;
    repeat (6) step();
    chk("t1_acks", 32'(ack_cnt[1]), 32'(4));
    drain();

    // 2: lower priority value wins
    en_v = 3'b111; prio_a[0] = 2'd2; prio_a[2] = 2'd1; req_v = 3'b101;
    step();
    chk("t2_first", 32'(ch_id_s), 32'(2));
    repeat (12) step();
    drain();

    // 3: round-robin among equal priorities
    quiet_inputs(); en_v = 3'b111; req_v = 3'b111; val_v = 3'b111; ready = 1'b1;
    repeat (32) step();
    drain();

    // 4: back-pressure with an 8-word packet
    quiet_inputs(); en_v = 3'b001; req_v = 3'b001; val_v = 3'b111; len_a[0] = 3'd1;
    step();
    req_v = '0;
    for (int c = 0; c < 20; c++) begin
      ready = (c % 2 == 0);
      step();
    end
    chk("t4_acks", 32'(ack_cnt[0]), 32'(8));
    drain();

    // 5: config changes mid-packet do not affect it; disabled channel not regranted
    quiet_inputs(); en_v = 3'b100; req_v = 3'b100; val_v = 3'b111; ready = 1'b1;
    repeat (2) step();
    len_a[2] = 3'd3; en_v = 3'b000;
    repeat (10) step();
    chk("t5_acks", 32'(ack_cnt[2]), 32'(4));
    drain();

    // reserved length code
    quiet_inputs(); en_v = 3'b001; req_v = 3'b001; val_v = 3'b111; ready = 1'b1; len_a[0] = 3'd7;
    step();
    req_v = '0;
    repeat (36) step();
    chk("len7_acks", 32'(ack_cnt[0]), 32'(32));
    drain();

    // 6: async reset during word 2
    quiet_inputs(); en_v = 3'b010; req_v = 3'b010; val_v = 3'b111; ready = 1'b1;
    for (int c = 0; c < 12 && !(m_busy && m_left == 2); c++) step();
    if (!(m_busy && m_left == 2)) chk("t6_budget", 32'(0), 32'(1));
    #2 rstn = 1'b0;
    #1 chk_all_zero("t6_async");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    en_v = 3'b111; req_v = 3'b111;
    step();
    chk("t6_first_tie", 32'(ch_id_s), 32'(0));
    repeat (10) step();
    drain();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 49) == 0) begin
        for (int i = 0; i < NCH; i++) begin
          prio_a[i] = 2'($urandom_range(0, 3));
          len_a[i]  = 3'($urandom_range(0, 7));
          en_v[i]   = ($urandom_range(0, 4) != 0);
        end
      end
      for (int i = 0; i < NCH; i++) begin
        req_v[i]  = ($urandom_range(0, 3) != 0);
        val_v[i]  = ($urandom_range(0, 3) != 0);
        data_a[i] = $urandom;
      end
      ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
